// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencing controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, bit-reversal helper over a run-time width
// (up to MAX_LOG2N bits), and the stage-index width helper.
package fft_pkg;

    localparam int MAX_LOG2N = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    // Bits needed to hold a stage index 0..log2n-1 (never narrower than 1).
    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                     input int                   w);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_delay.sv
// Fixed-depth delay line with synchronous clear.
// Latency: DEPTH cycles from i_din to o_dout.
// Backpressure: none; shifts every cycle.
//
// Ports: i_clk clock, i_clr synchronous clear (all stages to zero),
//        i_din data in, o_dout data delayed DEPTH cycles.
module clock_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Address/strobe sequencer for an N = 2^LOG2N point radix-2 DIT FFT.
// Latency: first rd_en one cycle after start; wr_* trail rd_* by PIPE_LAT.
// Backpressure: none; one butterfly per cycle, start ignored unless IDLE.
//
// Optional feature macro: FFT_SEQ_BITREV_EN (stage-0 read addresses are
// bit-reversed so input can be loaded in natural order).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start_fft, i_inverse  start request (IDLE only), IFFT mode latched on start
//   o_busy, o_fft_done      running flag, one-cycle completion pulse
//   o_bank_select, o_stage  bank read this stage (other bank written), stage index
//   o_rd_en, o_rd_addr_a/b  butterfly issue strobe and read addresses
//   o_tw_addr, o_tw_conj    twiddle ROM address (aligned with reads), conjugate flag
//   o_wr_en, o_wr_addr_a/b  write strobe and natural-order write addresses
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N    = 5,
    parameter int PIPE_LAT = 9
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start_fft,
    input  logic                        i_inverse,
    output logic                        o_busy,
    output logic                        o_fft_done,
    output logic                        o_bank_select,
    output logic [stage_w(LOG2N)-1:0]   o_stage,
    output logic                        o_rd_en,
    output logic [LOG2N-1:0]            o_rd_addr_a,
    output logic [LOG2N-1:0]            o_rd_addr_b,
    output logic [LOG2N-2:0]            o_tw_addr,
    output logic                        o_tw_conj,
    output logic                        o_wr_en,
    output logic [LOG2N-1:0]            o_wr_addr_a,
    output logic [LOG2N-1:0]            o_wr_addr_b
);

    localparam int SW    = stage_w(LOG2N);
    localparam int KW    = LOG2N - 1;
    localparam int TW_W  = LOG2N - 1;
    localparam int DW    = $clog2(PIPE_LAT + 1);
    localparam int DLY_W = 2 * LOG2N + 1;

    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

    if (LOG2N < 2 || LOG2N > MAX_LOG2N || PIPE_LAT < 1) begin : g_param_err
        $error("fft_seq_ctrl: LOG2N must be 2..12 and PIPE_LAT >= 1");
    end

    fft_state_t      r_state;
    logic [KW-1:0]   r_k;
    logic [DW-1:0]   r_drain;
    logic [SW-1:0]   r_stage;
    logic            r_bank;
    logic            r_conj;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [LOG2N-1:0] r_nat_a;
    logic [LOG2N-1:0] r_nat_b;
    logic [LOG2N-1:0] r_rd_a;
    logic [LOG2N-1:0] r_rd_b;
    logic [TW_W-1:0]  r_tw;

    logic [KW-1:0]    w_calc_k;
    logic [SW-1:0]    w_calc_s;
    logic [LOG2N-1:0] w_kk;
    logic [LOG2N-1:0] w_lo;
    logic [LOG2N-1:0] w_nat_a;
    logic [LOG2N-1:0] w_nat_b;
    logic [LOG2N-1:0] w_rd_a;
    logic [LOG2N-1:0] w_rd_b;
    logic [TW_W-1:0]  w_tw;
    logic [DLY_W-1:0] w_dly_in;
    logic [DLY_W-1:0] w_dly_out;

    // The address registers are loaded one cycle ahead of use, so the
    // generator works on the butterfly that will be presented next:
    // k+1 while issuing, (k=0, stage+1) at the end of a drain, (0,0) from IDLE.
    always_comb begin
        w_calc_k = '0;
        w_calc_s = '0;
        case (r_state)
            ST_ISSUE: begin
                w_calc_k = r_k + 1'b1;
                w_calc_s = r_stage;
            end
            ST_DRAIN: begin
                w_calc_s = (r_stage == S_LAST) ? r_stage : r_stage + 1'b1;
            end
            default: ;
        endcase
    end

    // a inserts a zero at bit position s of k; b sets that bit.
    // Twiddle index is the low s bits of k scaled up to the N/2-entry ROM.
    always_comb begin
        w_kk    = {1'b0, w_calc_k};
        w_lo    = w_kk & ((LOG2N'(1) << w_calc_s) - LOG2N'(1));
        w_nat_a = (((w_kk >> w_calc_s) << w_calc_s) << 1) | w_lo;
        w_nat_b = w_nat_a + (LOG2N'(1) << w_calc_s);
        w_tw    = TW_W'(w_lo << (LOG2N - 1 - int'(w_calc_s)));
        w_rd_a  = w_nat_a;
        w_rd_b  = w_nat_b;
`ifdef FFT_SEQ_BITREV_EN
        // Only the first pass reads scrambled; writes always land in natural order.
        if (w_calc_s == '0) begin
            w_rd_a = LOG2N'(bitrev(MAX_LOG2N'(w_nat_a), LOG2N));
            w_rd_b = LOG2N'(bitrev(MAX_LOG2N'(w_nat_b), LOG2N));
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_drain <= '0;
            r_stage <= '0;
            r_bank  <= 1'b0;
            r_conj  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_nat_a <= '0;
            r_nat_b <= '0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start_fft) begin
                        r_state <= ST_ISSUE;
                        r_conj  <= i_inverse;
                        r_stage <= '0;
                        r_bank  <= 1'b0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_nat_a <= w_nat_a;
                        r_nat_b <= w_nat_b;
                        r_rd_a  <= w_rd_a;
                        r_rd_b  <= w_rd_b;
                        r_tw    <= w_tw;
                    end
                end
                ST_ISSUE: begin
                    if (r_k == K_LAST) begin
                        r_state <= ST_DRAIN;
                        r_k     <= '0;
                        r_drain <= '0;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_k     <= w_calc_k;
                        r_nat_a <= w_nat_a;
                        r_nat_b <= w_nat_b;
                        r_rd_a  <= w_rd_a;
                        r_rd_b  <= w_rd_b;
                        r_tw    <= w_tw;
                    end
                end
                ST_DRAIN: begin
                    // The last write of the stage lands in this final drain
                    // cycle, so the bank may flip on the same edge.
                    if (r_drain == D_LAST) begin
                        r_drain <= '0;
                        r_bank  <= ~r_bank;
                        if (r_stage == S_LAST) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_stage <= w_calc_s;
                            r_k     <= '0;
                            r_rd_en <= 1'b1;
                            r_nat_a <= w_nat_a;
                            r_nat_b <= w_nat_b;
                            r_rd_a  <= w_rd_a;
                            r_rd_b  <= w_rd_b;
                            r_tw    <= w_tw;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write side is the natural-order issue stream delayed by the datapath latency.
    assign w_dly_in = {r_rd_en, r_nat_a, r_nat_b};

    clock_delay #(
        .WIDTH (DLY_W),
        .DEPTH (PIPE_LAT)
    ) u_wr_dly (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_din  (w_dly_in),
        .o_dout (w_dly_out)
    );

    assign o_wr_en       = w_dly_out[DLY_W-1];
    assign o_wr_addr_a   = w_dly_out[2*LOG2N-1:LOG2N];
    assign o_wr_addr_b   = w_dly_out[LOG2N-1:0];

    assign o_busy        = r_busy;
    assign o_fft_done    = r_done;
    assign o_bank_select = r_bank;
    assign o_stage       = r_stage;
    assign o_rd_en       = r_rd_en;
    assign o_rd_addr_a   = r_rd_a;
    assign o_rd_addr_b   = r_rd_b;
    assign o_tw_addr     = r_tw;
    assign o_tw_conj     = r_conj;

endmodule
